matrix_vec_seq: RTL and testbench
=================================

Name: matrix_vec_seq

Overview:
- Sequential fixed-point matrix-vector multiply engine: out[r] = sat(sum over c of A[c]*B[r][c], shifted right by FRAC_BITS).
- Successor to our combinational matrix unit. Adds parametrised fraction position, signed/unsigned mode, full-precision accumulation and symmetric saturation.
- Uses one MAC per cycle, with valid/ready handshakes on input and output.
- Sits between the operand buffers and the activation stage of the compute datapath.

Parameters:
- DATA_SIZE, 16: element width in bits.
- COLUMN_SIZE, 16: vector length, i.e. MACs per output element.
- ROW_SIZE, 16: number of output elements (matrix rows).
- FRAC_BITS, 16: right shift applied to the accumulated sum. Legal range 0..2*DATA_SIZE-1.
- SIGNED_MODE, 0: 0 = unsigned operands and result, 1 = two's-complement.

Ports:
- clock, in, 1: single clock, rising edge.
- reset, in, 1: asynchronous, active-low; clears all state.
- enable, in, 1: global advance; when low the block freezes.
- in_valid, in, 1: operand set presented.
- in_ready, out, 1: block can capture operands.
- datsA, in, DATA_SIZE*COLUMN_SIZE: vector; element c at [c*DATA_SIZE +: DATA_SIZE].
- datsB, in, DATA_SIZE*COLUMN_SIZE*ROW_SIZE: matrix; row r at [r*DATA_SIZE*COLUMN_SIZE +: DATA_SIZE*COLUMN_SIZE], element c within the row at [c*DATA_SIZE +: DATA_SIZE].
- out_valid, out, 1: result available.
- out_ready, in, 1: consumer accepts the result.
- datsOut, out, DATA_SIZE*ROW_SIZE: result; element r at [r*DATA_SIZE +: DATA_SIZE].
- sat_flag, out, 1: at least one element of the current result was saturated.
- busy, out, 1: high in RUN.

Behaviour:
- Reset (reset=0, async): state=IDLE, row/col counters=0, acc=0, datsOut=0, out_valid=0, sat_flag=0, busy=0, in_ready=0 while reset is held. Reset mid-RUN or mid-DONE discards the operation; no partial output.
- FSM IDLE -> RUN -> DONE -> IDLE. All transitions are qualified by enable=1.
- enable=0: state, counters, acc and outputs hold; in_ready=0; out_valid keeps its value; an out_ready pulse is ignored.
- IDLE:
  - in_ready = enable.
  - On in_valid&in_ready: latch datsA and datsB into internal registers, r=c=0, acc=0, clear sat_flag, go RUN.
- RUN: one MAC per enabled cycle.
  - acc += A[c]*B[r][c], as a full 2*DATA_SIZE product, sign-extended when SIGNED_MODE=1.
  - Accumulator width ACC_W = 2*DATA_SIZE + clog2(COLUMN_SIZE) + 1, so the sum never overflows.
  - On c==COLUMN_SIZE-1, this sequence on the same edge:
    - Compute res = (acc + product) >>> FRAC_BITS: arithmetic shift, truncating toward minus infinity.
    - Saturate res to [0, 2^DATA_SIZE-1] in unsigned mode, or [-2^(DATA_SIZE-1), 2^(DATA_SIZE-1)-1] in signed mode.
    - Write it to datsOut element r; OR any clip into sat_flag.
    - Set acc=0, c=0, r=r+1.
  - On r==ROW_SIZE-1 and c==COLUMN_SIZE-1: go DONE.
  - in_ready=0 throughout RUN.
- Latency: exactly ROW_SIZE*COLUMN_SIZE enabled cycles from the capture edge to the edge raising out_valid.
- DONE:
  - out_valid=1; datsOut and sat_flag are stable.
  - On out_ready&enable: out_valid=0, go IDLE.
  - Next capture is possible no earlier than the cycle after acceptance; no overlap.
- datsOut keeps the last result after acceptance until overwritten row by row in the next RUN.
- Input operands may change freely after capture.

Decomposition:
- Shared package: ACC_W function; clog2; FSM state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
- Sub-module mac_sat_unit holds the combinational multiply, accumulate, shift and saturate, parametrised by DATA_SIZE, ACC_W, FRAC_BITS and SIGNED_MODE.
- The top level holds the FSM, counters and operand registers.

Test Plan:
- Unsigned scaling (defaults): A[0]=0x8000, other A=0; B[r][0]=0x0100*(r+1) -> out[r]=0x0080*(r+1). out_valid rises 256 enabled cycles after capture; sat_flag=0.
- Unsigned saturation (defaults): all A=0x8000, all B=0x8000 -> every out[r]=0xFFFF (sum 0x4_0000_0000 >> 16 = 0x40000 clips); sat_flag=1.
- Signed (SIGNED_MODE=1, FRAC_BITS=15):
  - A[0]=0xC000, B[0][0]=0x4000, all other elements 0 -> out[0]=0xE000, others 0x0000.
  - All A=0x8000, B row 0 all 0x7FFF -> out[0]=0x8000, sat_flag=1.
- Handshake: hold out_ready=0 for 10 cycles after out_valid -> datsOut/out_valid stable, in_ready=0. Raising out_ready gives out_valid=0 on the next edge and in_ready=1 in IDLE.
- Enable stall: drop enable for 5 cycles mid-RUN -> counters freeze; out_valid arrives exactly 5 cycles late with identical results.
- Reset mid-RUN: assert reset at MAC 100 -> outputs immediately 0, state IDLE. A fresh operation after release gives the correct result with no residue.

Source files
------------

// File: rtl/matrix_vec_seq_pkg.sv
// Shared types and sizing helpers for the sequential matrix-vector engine.
package matrix_vec_seq_pkg;

   // Controller states; the encoding is visible on the debug state output.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Ceiling log2; clog2(1) = 0.
   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = 1;
      while (v < n) begin
         v = v << 1;
         r++;
      end
      return r;
   endfunction

   // Accumulator width: full product plus growth for COLUMN_SIZE terms plus a sign bit.
   function automatic int acc_w(input int data_size, input int column_size);
      return 2 * data_size + clog2(column_size) + 1;
   endfunction

   // Counter width, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (clog2(n) > 0) ? clog2(n) : 1;
   endfunction

endpackage

// File: rtl/matrix_vec_seq_if.sv
// Operand/result bus of the matrix-vector engine.
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high; valid is never withdrawn before that edge, and the payload
// is stable while valid is high.
interface matrix_vec_seq_if #(
   parameter int DATA_SIZE   = 16,
   parameter int COLUMN_SIZE = 16,
   parameter int ROW_SIZE    = 16
);
   logic                                    in_valid;
   logic                                    in_ready;
   logic [DATA_SIZE*COLUMN_SIZE-1:0]          datsA;
   logic [DATA_SIZE*COLUMN_SIZE*ROW_SIZE-1:0] datsB;
   logic                                    out_valid;
   logic                                    out_ready;
   logic [DATA_SIZE*ROW_SIZE-1:0]             datsOut;
   logic                                    sat_flag;

   // Producer/consumer side (operand buffers and activation stage).
   modport master (
      output in_valid, datsA, datsB, out_ready,
      input  in_ready, out_valid, datsOut, sat_flag
   );

   // Engine side.
   modport slave (
      input  in_valid, datsA, datsB, out_ready,
      output in_ready, out_valid, datsOut, sat_flag
   );
endinterface

// File: rtl/matrix_vec_seq_mac_sat_unit.sv
// Combinational multiply-accumulate, fraction shift and saturation for one MAC step.
module mac_sat_unit #(
   parameter int DATA_SIZE   = 16,
   parameter int ACC_W       = 37,
   parameter int FRAC_BITS   = 16,
   parameter int SIGNED_MODE = 0
) (
   input  logic [DATA_SIZE-1:0] a,
   input  logic [DATA_SIZE-1:0] b,
   input  logic [ACC_W-1:0]     acc,
   output logic [ACC_W-1:0]     acc_sum,
   output logic [DATA_SIZE-1:0] res,
   output logic                 clip
);
   localparam int PW  = 2 * DATA_SIZE;
   localparam int EXT = ACC_W - PW;

   logic [PW-1:0]          prod_u;
   logic signed [PW-1:0]   prod_s;
   logic [ACC_W-1:0]       prod_ext;
   logic signed [ACC_W-1:0] shifted;
   logic [ACC_W-DATA_SIZE:0]   hi_s;
   logic [ACC_W-DATA_SIZE-1:0] hi_u;

   // Operands are widened explicitly so the product is full precision in both modes.
   assign prod_u   = {{DATA_SIZE{1'b0}}, a} * {{DATA_SIZE{1'b0}}, b};
   assign prod_s   = $signed({{DATA_SIZE{a[DATA_SIZE-1]}}, a}) * $signed({{DATA_SIZE{b[DATA_SIZE-1]}}, b});
   assign prod_ext = (SIGNED_MODE != 0) ? {{EXT{prod_s[PW-1]}}, prod_s} : {{EXT{1'b0}}, prod_u};
   assign acc_sum  = acc + prod_ext;

   // Arithmetic shift floors toward minus infinity; in unsigned mode the MSB is always 0.
   assign shifted = $signed(acc_sum) >>> FRAC_BITS;
   assign hi_s    = shifted[ACC_W-1:DATA_SIZE-1];
   assign hi_u    = shifted[ACC_W-1:DATA_SIZE];

   // Clip to the representable output range, flagging any clip.
   always_comb begin
      clip = 1'b0;
      res  = shifted[DATA_SIZE-1:0];
      if (SIGNED_MODE != 0) begin
         if (!((&hi_s) || !(|hi_s))) begin
            clip = 1'b1;
            res  = shifted[ACC_W-1] ? {1'b1, {(DATA_SIZE-1){1'b0}}}
                                    : {1'b0, {(DATA_SIZE-1){1'b1}}};
         end
      end else if (|hi_u) begin
         clip = 1'b1;
         res  = '1;
      end
   end
endmodule

// File: rtl/matrix_vec_seq.sv
// Sequential fixed-point matrix-vector multiply: one MAC per enabled cycle,
// row results written as each row completes, whole vector offered on DONE.
module matrix_vec_seq
   import matrix_vec_seq_pkg::*;
#(
   parameter int DATA_SIZE   = 16,
   parameter int COLUMN_SIZE = 16,
   parameter int ROW_SIZE    = 16,
   parameter int FRAC_BITS   = 16,
   parameter int SIGNED_MODE = 0
) (
   input  logic   clock,
   input  logic   reset,
   input  logic   enable,
   output logic   busy,
   output state_t state_dbg,
   matrix_vec_seq_if.slave bus
);
   localparam int ACC_W = acc_w(DATA_SIZE, COLUMN_SIZE);
   localparam int COL_W = cnt_w(COLUMN_SIZE);
   localparam int ROW_W = cnt_w(ROW_SIZE);
   localparam int VW    = DATA_SIZE * COLUMN_SIZE;
   localparam int MW    = VW * ROW_SIZE;
   localparam int OW    = DATA_SIZE * ROW_SIZE;

   state_t               state;
   logic [COL_W-1:0]     col;
   logic [ROW_W-1:0]     row;
   logic [ACC_W-1:0]     acc;
   logic [VW-1:0]        a_reg;
   logic [MW-1:0]        b_reg;
   logic [OW-1:0]        out_reg;
   logic                 out_valid_q;
   logic                 sat_q;

   logic [DATA_SIZE-1:0] a_el;
   logic [DATA_SIZE-1:0] b_el;
   logic [ACC_W-1:0]     acc_sum;
   logic [DATA_SIZE-1:0] res;
   logic                 clip;
   logic                 last_col;
   logic                 last_row;

   assign a_el     = a_reg[int'(col) * DATA_SIZE +: DATA_SIZE];
   assign b_el     = b_reg[(int'(row) * COLUMN_SIZE + int'(col)) * DATA_SIZE +: DATA_SIZE];
   assign last_col = (col == COL_W'(COLUMN_SIZE - 1));
   assign last_row = (row == ROW_W'(ROW_SIZE - 1));

   mac_sat_unit #(
      .DATA_SIZE   (DATA_SIZE),
      .ACC_W       (ACC_W),
      .FRAC_BITS   (FRAC_BITS),
      .SIGNED_MODE (SIGNED_MODE)
   ) u_mac (
      .a       (a_el),
      .b       (b_el),
      .acc     (acc),
      .acc_sum (acc_sum),
      .res     (res),
      .clip    (clip)
   );

   // in_ready is forced low while reset is held, even though IDLE is the reset state.
   assign bus.in_ready  = reset & enable & (state == ST_IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.datsOut   = out_reg;
   assign bus.sat_flag  = sat_q;
   assign busy          = (state == ST_RUN);
   assign state_dbg     = state;

   // Controller, counters, accumulator and result registers; everything holds when enable is low.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         col         <= '0;
         row         <= '0;
         acc         <= '0;
         a_reg       <= '0;
         b_reg       <= '0;
         out_reg     <= '0;
         out_valid_q <= 1'b0;
         sat_q       <= 1'b0;
      end else if (enable) begin
         case (state)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  a_reg <= bus.datsA;
                  b_reg <= bus.datsB;
                  col   <= '0;
                  row   <= '0;
                  acc   <= '0;
                  sat_q <= 1'b0;
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (last_col) begin
                  out_reg[int'(row) * DATA_SIZE +: DATA_SIZE] <= res;
                  sat_q <= sat_q | clip;
                  acc   <= '0;
                  col   <= '0;
                  if (last_row) begin
                     row         <= '0;
                     out_valid_q <= 1'b1;
                     state       <= ST_DONE;
                  end else begin
                     row <= row + ROW_W'(1);
                  end
               end else begin
                  acc <= acc_sum;
                  col <= col + COL_W'(1);
               end
            end
            ST_DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  state       <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_matrix_vec_seq.sv
// Bench for matrix_vec_seq: an unsigned default instance and a signed Q15 instance
// share the operand buses; sel picks which one is driven and observed.
module tb_matrix_vec_seq;
   import matrix_vec_seq_pkg::*;

   localparam int DS = 16;
   localparam int CS = 16;
   localparam int RS = 16;
   localparam int VW = DS * CS;
   localparam int MW = VW * RS;
   localparam int OW = DS * RS;
   localparam int RW = OW + 1;

   logic          clk;
   logic          rst_n;
   logic          en;
   logic          sel;
   logic          iv;
   logic          ordy;
   logic [VW-1:0] a_vec;
   logic [MW-1:0] b_mat;
   logic          busy_u, busy_s;
   state_t        st_u, st_s;
   logic          en_u, en_s;

   logic          o_valid, o_ready, o_sat, o_busy;
   logic [OW-1:0] o_dats;
   state_t        o_state;

   int            checks = 0;
   int            errors = 0;
   logic [RW-1:0] exp_q[$];

   // clock / reset block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   matrix_vec_seq_if #(.DATA_SIZE(DS), .COLUMN_SIZE(CS), .ROW_SIZE(RS)) bu ();
   matrix_vec_seq_if #(.DATA_SIZE(DS), .COLUMN_SIZE(CS), .ROW_SIZE(RS)) bs ();

   assign bu.in_valid  = iv & ~sel;
   assign bs.in_valid  = iv & sel;
   assign bu.out_ready = ordy & ~sel;
   assign bs.out_ready = ordy & sel;
   assign bu.datsA     = a_vec;
   assign bs.datsA     = a_vec;
   assign bu.datsB     = b_mat;
   assign bs.datsB     = b_mat;
   assign en_u         = sel ? 1'b1 : en;
   assign en_s         = sel ? en : 1'b1;

   assign o_valid = sel ? bs.out_valid : bu.out_valid;
   assign o_ready = sel ? bs.in_ready : bu.in_ready;
   assign o_sat   = sel ? bs.sat_flag : bu.sat_flag;
   assign o_dats  = sel ? bs.datsOut : bu.datsOut;
   assign o_busy  = sel ? busy_s : busy_u;
   assign o_state = sel ? st_s : st_u;

   matrix_vec_seq #(
      .DATA_SIZE(DS), .COLUMN_SIZE(CS), .ROW_SIZE(RS), .FRAC_BITS(16), .SIGNED_MODE(0)
   ) u_dut_u (
      .clock(clk), .reset(rst_n), .enable(en_u), .busy(busy_u), .state_dbg(st_u), .bus(bu)
   );

   matrix_vec_seq #(
      .DATA_SIZE(DS), .COLUMN_SIZE(CS), .ROW_SIZE(RS), .FRAC_BITS(15), .SIGNED_MODE(1)
   ) u_dut_s (
      .clock(clk), .reset(rst_n), .enable(en_s), .busy(busy_s), .state_dbg(st_s), .bus(bs)
   );

   task automatic check_eq(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   // Reference result from plain integer arithmetic: {sat, out[RS-1] .. out[0]}.
   function automatic logic [RW-1:0] model(input logic sgn, input int frac);
      logic [RW-1:0] r;
      longint sum, pa, pb, lo, hi, v;
      r  = '0;
      lo = sgn ? -(longint'(1) << (DS - 1)) : 64'sd0;
      hi = sgn ? (longint'(1) << (DS - 1)) - 1 : (longint'(1) << DS) - 1;
      for (int rr = 0; rr < RS; rr++) begin
         sum = 0;
         for (int c = 0; c < CS; c++) begin
            if (sgn) begin
               pa = longint'($signed(a_vec[c*DS +: DS]));
               pb = longint'($signed(b_mat[(rr*CS + c)*DS +: DS]));
            end else begin
               pa = longint'({48'd0, a_vec[c*DS +: DS]});
               pb = longint'({48'd0, b_mat[(rr*CS + c)*DS +: DS]});
            end
            sum += pa * pb;
         end
         v = sum >>> frac;
         if (v > hi) begin
            v     = hi;
            r[OW] = 1'b1;
         end else if (v < lo) begin
            v     = lo;
            r[OW] = 1'b1;
         end
         r[rr*DS +: DS] = v[DS-1:0];
      end
      return r;
   endfunction

   // driver tasks
   task automatic clear_ops();
      a_vec = '0;
      b_mat = '0;
   endtask

   task automatic set_a(input int c, input logic [DS-1:0] v);
      a_vec[c*DS +: DS] = v;
   endtask

   task automatic set_b(input int r, input int c, input logic [DS-1:0] v);
      b_mat[(r*CS + c)*DS +: DS] = v;
   endtask

   task automatic fill_rand(input int maxv);
      for (int c = 0; c < CS; c++) a_vec[c*DS +: DS] = DS'($urandom_range(0, maxv));
      for (int i = 0; i < CS*RS; i++) b_mat[i*DS +: DS] = DS'($urandom_range(0, maxv));
   endtask

   task automatic capture();
      int n;
      n = 0;
      @(negedge clk);
      iv = 1'b1;
      while (!o_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_eq("in_ready_idle", RW'(o_ready), RW'(1));
      @(posedge clk);
      #1;
      iv = 1'b0;
      check_eq("busy_after_capture", RW'(o_busy), RW'(1));
      check_eq("in_ready_in_run", RW'(o_ready), RW'(0));
      check_eq("sat_cleared", RW'(o_sat), RW'(0));
      // Operands are scrambled after capture; the engine must use its latched copy.
      fill_rand(32'hFFFF);
   endtask

   task automatic run_op(input int hold, input int stall_at, input int exp_lat);
      logic [RW-1:0] e;
      int cyc;
      cyc = 0;
      exp_q.push_back(model(sel, sel ? 15 : 16));
      capture();
      while (cyc < 3000) begin
         @(posedge clk);
         #1;
         cyc++;
         if (o_valid) break;
         if (!en) check_eq("stall_busy", RW'(o_busy), RW'(1));
         if (stall_at > 0 && cyc == stall_at) en = 1'b0;
         if (stall_at > 0 && cyc == stall_at + 5) en = 1'b1;
      end
      en = 1'b1;
      check_eq("out_valid", RW'(o_valid), RW'(1));
      check_eq("latency", RW'(cyc), RW'(exp_lat));
      e = exp_q.pop_front();
      check_eq("result", {o_sat, o_dats}, e);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         check_eq("hold_valid", RW'(o_valid), RW'(1));
         check_eq("hold_in_ready", RW'(o_ready), RW'(0));
         check_eq("hold_result", {o_sat, o_dats}, e);
      end
      if (hold > 0) begin
         en   = 1'b0;
         ordy = 1'b1;
         @(posedge clk);
         #1;
         check_eq("ready_ignored_disabled", RW'(o_valid), RW'(1));
         check_eq("in_ready_disabled", RW'(o_ready), RW'(0));
         ordy = 1'b0;
         en   = 1'b1;
      end
      ordy = 1'b1;
      @(posedge clk);
      #1;
      ordy = 1'b0;
      check_eq("accept_valid", RW'(o_valid), RW'(0));
      check_eq("accept_in_ready", RW'(o_ready), RW'(1));
      check_eq("accept_state", RW'(o_state), RW'(ST_IDLE));
      check_eq("kept_result", {o_sat, o_dats}, e);
   endtask

   task automatic reset_mid_run();
      logic [RW-1:0] e;
      exp_q.push_back(model(sel, sel ? 15 : 16));
      capture();
      repeat (100) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      e = exp_q.pop_back();
      check_eq("rst_mid_valid", RW'(o_valid), RW'(0));
      check_eq("rst_mid_dats", RW'(o_dats), RW'(0));
      check_eq("rst_mid_sat", RW'(o_sat), RW'(0));
      check_eq("rst_mid_busy", RW'(o_busy), RW'(0));
      check_eq("rst_mid_state", RW'(o_state), RW'(ST_IDLE));
      check_eq("rst_mid_in_ready", RW'(o_ready), RW'(0));
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      en    = 1'b1;
      sel   = 1'b0;
      iv    = 1'b0;
      ordy  = 1'b0;
      clear_ops();
      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         check_eq("rst_valid", RW'(o_valid), RW'(0));
         check_eq("rst_dats", RW'(o_dats), RW'(0));
         check_eq("rst_sat", RW'(o_sat), RW'(0));
         check_eq("rst_busy", RW'(o_busy), RW'(0));
         check_eq("rst_in_ready", RW'(o_ready), RW'(0));
         check_eq("rst_state", RW'(o_state), RW'(ST_IDLE));
      end
      sel = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // unsigned scaling: out[r] = 0x80*(r+1)
      clear_ops();
      set_a(0, 16'h8000);
      for (int r = 0; r < RS; r++) set_b(r, 0, DS'(32'h0100 * (r + 1)));
      run_op(0, 0, 256);

      // unsigned saturation with a held-off consumer
      a_vec = {CS{16'h8000}};
      b_mat = {CS*RS{16'h8000}};
      run_op(10, 0, 256);

      // enable stall mid-RUN
      fill_rand(32'h0FFF);
      run_op(0, 100, 261);

      // reset mid-RUN, then a fresh operation
      fill_rand(32'hFFFF);
      reset_mid_run();
      fill_rand(32'h03FF);
      run_op(0, 0, 256);

      // random unsigned
      fill_rand(32'h0FFF);
      run_op(0, 0, 256);
      fill_rand(32'hFFFF);
      run_op(0, 0, 256);

      // signed Q15 instance
      sel = 1'b1;
      clear_ops();
      set_a(0, 16'hC000);
      set_b(0, 0, 16'h4000);
      run_op(0, 0, 256);

      clear_ops();
      a_vec = {CS{16'h8000}};
      for (int c = 0; c < CS; c++) set_b(0, c, 16'h7FFF);
      run_op(0, 0, 256);

      fill_rand(32'hFFFF);
      run_op(0, 0, 256);
      fill_rand(32'h00FF);
      run_op(3, 0, 256);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
